// File: rtl/mtds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mtds_pkg
// Purpose  : Shared types, default parameter values and the result
//            reduction helper for the multi-tap delay-and-scale engine.
// Contents : mtds_state_e  - engine FSM states (IDLE, RUN, DRAIN)
//            c_def_*       - default parameter values
//            sat_trunc()   - reduce a wide signed result to out_w bits
// Macro    : MTDS_SATURATE_EN - clamp instead of wrapping in sat_trunc()
// Revision : 1.0 - initial release
// ============================================================================
package mtds_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } mtds_state_e;

  localparam int c_def_w         = 16;
  localparam int c_def_depth     = 256;
  localparam int c_def_n_taps    = 4;
  localparam int c_def_scale_w   = 9;
  localparam int c_def_frac_bits = 6;

  // Reduce a sign-extended value to an out_w-bit two's-complement range.
  // The result is returned sign-extended to 64 bits; callers keep the low
  // out_w bits.
  function automatic logic signed [63:0] sat_trunc(
    input logic signed [63:0] val,
    input int unsigned        out_w
  );
`ifdef MTDS_SATURATE_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (val > hi)
      return hi;
    else if (val < lo)
      return lo;
    else
      return val;
`else
    // Keep the low out_w bits and re-extend their sign bit.
    return (val <<< (64 - out_w)) >>> (64 - out_w);
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_tap_delay_scale_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_tap_delay_scale_if
// Purpose  : Sample/configuration/result bundle of the delay-and-scale engine.
// Ports    : ready_in    - new-sample strobe
//            signal_in   - signed input sample (W)
//            delays_in   - per-tap delays, tap k at [k*AW +: AW]
//            scales_in   - per-tap signed gains, tap k at [k*SCALE_W +: SCALE_W]
//            signal_out  - signed weighted sum (W)
//            done_out    - result-updated pulse
//            busy_out    - computation in progress
//            dropped_out - strobe-ignored pulse
// Modports : master (sample source side), slave (engine side)
// Revision : 1.0 - initial release
// ============================================================================
interface multi_tap_delay_scale_if
  import mtds_pkg::*;
#(
  parameter int W       = c_def_w,
  parameter int DEPTH   = c_def_depth,
  parameter int N_TAPS  = c_def_n_taps,
  parameter int SCALE_W = c_def_scale_w
);
  localparam int AW = $clog2(DEPTH);

  logic                        ready_in;
  logic [W-1:0]                signal_in;
  logic [N_TAPS*AW-1:0]        delays_in;
  logic [N_TAPS*SCALE_W-1:0]   scales_in;
  logic [W-1:0]                signal_out;
  logic                        done_out;
  logic                        busy_out;
  logic                        dropped_out;

  modport master (
    output ready_in, signal_in, delays_in, scales_in,
    input  signal_out, done_out, busy_out, dropped_out
  );

  modport slave (
    input  ready_in, signal_in, delays_in, scales_in,
    output signal_out, done_out, busy_out, dropped_out
  );

endinterface
`default_nettype wire

// File: rtl/mtds_history_ram.sv
`default_nettype none
// ============================================================================
// Module   : mtds_history_ram
// Purpose  : DEPTH x W simple dual-port sample history, one write port and
//            one synchronous (one-cycle) read port. Contents are not reset.
// Ports    : clk_in  - clock
//            wr_en   - write strobe,  wr_addr / wr_data
//            rd_en   - read strobe,   rd_addr -> rd_data next cycle
// Revision : 1.0 - initial release
// ============================================================================
module mtds_history_ram
  import mtds_pkg::*;
#(
  parameter int W     = c_def_w,
  parameter int DEPTH = c_def_depth
)(
  input  logic                     clk_in,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en)
      r_mem[wr_addr] <= wr_data;
    if (rd_en)
      rd_data <= r_mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/multi_tap_delay_scale.sv
`default_nettype none
// ============================================================================
// Module   : multi_tap_delay_scale
// Purpose  : Multi-tap delay-and-scale engine. Each accepted sample is stored
//            in a circular history; the output is the floor-scaled sum of
//            N_TAPS delayed samples, each with its own signed gain.
// Ports    : clk_in    - clock, rising edge
//            rst_n_in  - asynchronous active-low reset
//            bus       - multi_tap_delay_scale_if.slave (sample in, result out)
// Macro    : MTDS_SATURATE_EN - clamp the result instead of wrapping it
// Revision : 1.0 - initial release
// ============================================================================
module multi_tap_delay_scale
  import mtds_pkg::*;
#(
  parameter int W         = c_def_w,
  parameter int DEPTH     = c_def_depth,
  parameter int N_TAPS    = c_def_n_taps,
  parameter int SCALE_W   = c_def_scale_w,
  parameter int FRAC_BITS = c_def_frac_bits
)(
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  multi_tap_delay_scale_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int TW    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int PW    = W + SCALE_W;
  localparam int ACC_W = W + SCALE_W + $clog2(N_TAPS) + 1;

  localparam logic [TW-1:0] c_last_tap = TW'(N_TAPS - 1);
  localparam logic [AW:0]   c_fill_max = (AW + 1)'(DEPTH);

  mtds_state_e                r_state;
  logic [AW-1:0]              r_wr_ptr;
  logic [AW:0]                r_fill;
  logic [AW-1:0]              r_base;      // address the current sample went to
  logic [N_TAPS*AW-1:0]       r_delays;
  logic [N_TAPS*SCALE_W-1:0]  r_scales;
  logic [TW-1:0]              r_tap;
  logic                       r_rd_vld;    // RAM data this cycle belongs to a tap
  logic                       r_rd_mask;   // that tap pointed past the fill level
  logic signed [SCALE_W-1:0]  r_rd_scale;  // gain of that tap
  logic signed [ACC_W-1:0]    r_acc;
  logic [W-1:0]               r_signal_out;
  logic                       r_done;
  logic                       r_busy;
  logic                       r_dropped;

  logic                       w_accept;
  logic [AW-1:0]              w_cur_delay;
  logic [AW-1:0]              w_rd_addr;
  logic                       w_cur_masked;
  logic signed [W-1:0]        w_rd_data;
  logic signed [PW-1:0]       w_prod;
  logic signed [ACC_W-1:0]    w_addend;
  logic signed [ACC_W-1:0]    w_shift;
  logic signed [63:0]         w_shift_ext;

  assign w_accept     = (r_state == IDLE) && bus.ready_in;
  assign w_cur_delay  = r_delays[r_tap*AW +: AW];
  assign w_rd_addr    = r_base - w_cur_delay;
  // An entry d strobes back exists only once more than d samples arrived.
  assign w_cur_masked = ({1'b0, w_cur_delay} >= r_fill);

  assign w_prod   = w_rd_data * r_rd_scale;
  assign w_addend = r_rd_mask ? '0 : {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};

  assign w_shift     = r_acc >>> FRAC_BITS;
  assign w_shift_ext = {{(64-ACC_W){w_shift[ACC_W-1]}}, w_shift};

  mtds_history_ram #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_history (
    .clk_in  (clk_in),
    .wr_en   (w_accept),
    .wr_addr (r_wr_ptr),
    .wr_data (bus.signal_in),
    .rd_en   (r_state == RUN),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      r_base       <= '0;
      r_delays     <= '0;
      r_scales     <= '0;
      r_tap        <= '0;
      r_rd_vld     <= 1'b0;
      r_rd_mask    <= 1'b0;
      r_rd_scale   <= '0;
      r_acc        <= '0;
      r_signal_out <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_dropped    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      // Covers RUN and both DRAIN cycles, including the one that exits to IDLE.
      r_dropped <= (r_state != IDLE) && bus.ready_in;
      r_rd_vld  <= 1'b0;
      if (r_rd_vld)
        r_acc <= r_acc + w_addend;

      case (r_state)
        IDLE: begin
          // busy stays up through the done cycle and drops here
          r_busy <= bus.ready_in;
          if (bus.ready_in) begin
            r_base   <= r_wr_ptr;
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_fill != c_fill_max)
              r_fill <= r_fill + 1'b1;
            r_delays <= bus.delays_in;
            r_scales <= bus.scales_in;
            r_acc    <= '0;
            r_tap    <= '0;
            r_state  <= RUN;
          end
        end

        RUN: begin
          r_rd_vld   <= 1'b1;
          r_rd_mask  <= w_cur_masked;
          r_rd_scale <= r_scales[r_tap*SCALE_W +: SCALE_W];
          if (r_tap == c_last_tap)
            r_state <= DRAIN;
          else
            r_tap <= r_tap + 1'b1;
        end

        DRAIN: begin
          // First DRAIN cycle folds in the last tap; the second publishes.
          if (!r_rd_vld) begin
            r_signal_out <= W'(sat_trunc(w_shift_ext, W));
            r_done       <= 1'b1;
            r_state      <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.signal_out  = r_signal_out;
  assign bus.done_out    = r_done;
  assign bus.busy_out    = r_busy;
  assign bus.dropped_out = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_multi_tap_delay_scale.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_tap_delay_scale
// Purpose  : Self-checking bench for multi_tap_delay_scale at default
//            parameters. Expected results come from a table of hand-derived
//            vectors and from a queue-based reference model of the tap sum.
// Macro    : MTDS_SATURATE_EN - selects clamped vs wrapped expectations
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_tap_delay_scale;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;

  always #5 clk_in = ~clk_in;

  multi_tap_delay_scale_if #(.W(16), .DEPTH(256), .N_TAPS(4), .SCALE_W(9)) bus ();

  multi_tap_delay_scale #(
    .W(16), .DEPTH(256), .N_TAPS(4), .SCALE_W(9), .FRAC_BITS(6)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference history: every accepted sample since the last reset.
  int hist[$];

  typedef struct {
    logic signed [15:0] s;
    logic [31:0]        d;
    logic [35:0]        g;
    logic signed [15:0] exp;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [31:0] pd(input int a, input int b, input int c, input int e);
    return {8'(e), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [35:0] pg(input int a, input int b, input int c, input int e);
    return {9'(e), 9'(c), 9'(b), 9'(a)};
  endfunction

  // Output = floor(sum of gain * sample-d-strobes-ago / 64), missing history
  // counts as zero, then clamped or wrapped to 16 bits.
  function automatic logic signed [15:0] model(input logic signed [15:0] s,
                                               input logic [31:0] d,
                                               input logic [35:0] g);
    longint acc = 0;
    longint res;
    longint gk;
    int     n;
    int     dk;
    hist.push_back(int'(s));
    n = hist.size();
    for (int k = 0; k < 4; k++) begin
      dk = int'(d[k*8 +: 8]);
      gk = longint'($signed(g[k*9 +: 9]));
      if (dk < n)
        acc += longint'(hist[n-1-dk]) * gk;
    end
    res = acc >>> 6;
`ifdef MTDS_SATURATE_EN
    if (res > 32767)
      res = 32767;
    else if (res < -32768)
      res = -32768;
`endif
    return 16'(res);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    hist.delete();
  endtask

  // Present one sample, scramble the config after acceptance, and wait for
  // done_out. lat is the edge count from the sampling edge, -1 on timeout.
  task automatic run_one(input logic signed [15:0] s, input logic [31:0] d,
                         input logic [35:0] g,
                         output logic signed [15:0] out, output int lat);
    @(negedge clk_in);
    bus.ready_in  = 1'b1;
    bus.signal_in = s;
    bus.delays_in = d;
    bus.scales_in = g;
    @(posedge clk_in);
    #1;
    bus.ready_in  = 1'b0;
    bus.delays_in = $urandom;
    bus.scales_in = {4'($urandom), $urandom};
    lat = -1;
    out = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_in);
      #1;
      if (bus.done_out) begin
        lat = i;
        out = bus.signal_out;
        break;
      end
    end
  endtask

  logic signed [15:0] out;
  logic signed [15:0] exp;
  int                 lat;
  int                 ndone;

  initial begin
    bus.ready_in  = 1'b0;
    bus.signal_in = '0;
    bus.delays_in = '0;
    bus.scales_in = '0;

    // ---------------- table of hand-derived vectors ----------------
    tbl[0] = '{16'sd1000,   pd(0, 3, 0, 0), pg(64, -32, 0, 0), 16'sd1000};
    tbl[1] = '{16'sd0,      pd(0, 3, 0, 0), pg(64, -32, 0, 0), 16'sd0};
    tbl[2] = '{16'sd0,      pd(0, 3, 0, 0), pg(64, -32, 0, 0), 16'sd0};
    tbl[3] = '{16'sd0,      pd(0, 3, 0, 0), pg(64, -32, 0, 0), -16'sd500};
`ifdef MTDS_SATURATE_EN
    tbl[4] = '{16'sd32767,  pd(0, 0, 0, 0), pg(64, 64, 0, 0),  16'sd32767};
    tbl[5] = '{-16'sd32768, pd(0, 0, 0, 0), pg(64, 64, 0, 0), -16'sd32768};
`else
    tbl[4] = '{16'sd32767,  pd(0, 0, 0, 0), pg(64, 64, 0, 0),  -16'sd2};
    tbl[5] = '{-16'sd32768, pd(0, 0, 0, 0), pg(64, 64, 0, 0),  16'sd0};
`endif
    tbl[6] = '{16'sd1,      pd(0, 0, 0, 0), pg(-32, 0, 0, 0),  -16'sd1};
    tbl[7] = '{16'sd100,    pd(0, 1, 2, 3), pg(64, 64, 64, 64), 16'sd100};
    tbl[8] = '{-16'sd7,     pd(1, 0, 0, 0), pg(32, 1, 0, 0),    16'sd49};

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk_in);
    check("reset_signal_out", longint'($signed(bus.signal_out)), 0);
    check("reset_done_out", longint'(bus.done_out), 0);
    check("reset_busy_out", longint'(bus.busy_out), 0);
    check("reset_dropped_out", longint'(bus.dropped_out), 0);
    rst_n_in = 1'b1;

    // ---------------- impulse ----------------
    run_one(16'sd1000, pd(0, 0, 0, 0), pg(64, 0, 0, 0), out, lat);
    check("impulse_latency", lat, 6);
    check("impulse_value", out, 1000);
    check("impulse_busy_in_done_cycle", longint'(bus.busy_out), 1);
    @(posedge clk_in);
    #1;
    check("impulse_done_single", longint'(bus.done_out), 0);
    check("impulse_busy_after", longint'(bus.busy_out), 0);

    // ---------------- table (echo, saturation, floor, mixed) ----------------
    do_reset();
    foreach (tbl[i]) begin
      exp = model(tbl[i].s, tbl[i].d, tbl[i].g);
      run_one(tbl[i].s, tbl[i].d, tbl[i].g, out, lat);
      check($sformatf("tbl%0d_value", i), out, tbl[i].exp);
      check($sformatf("tbl%0d_model", i), out, exp);
      check($sformatf("tbl%0d_latency", i), lat, 6);
    end

    // ---------------- busy collision ----------------
    do_reset();
    @(negedge clk_in);
    bus.ready_in  = 1'b1;
    bus.signal_in = 16'sd500;
    bus.delays_in = pd(0, 0, 0, 0);
    bus.scales_in = pg(64, 0, 0, 0);
    exp = model(16'sd500, pd(0, 0, 0, 0), pg(64, 0, 0, 0));
    @(posedge clk_in);
    #1;
    bus.ready_in = 1'b0;
    @(negedge clk_in);
    bus.ready_in  = 1'b1;
    bus.signal_in = -16'sd1234;
    @(posedge clk_in);
    #1;
    bus.ready_in = 1'b0;
    check("collision_dropped", longint'(bus.dropped_out), 1);
    ndone = 0;
    out   = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in);
      #1;
      if (bus.done_out) begin
        ndone++;
        out = bus.signal_out;
      end
    end
    check("collision_done_count", ndone, 1);
    check("collision_value", out, exp);

    // Strobe landing on the edge where DRAIN hands back to IDLE.
    @(negedge clk_in);
    bus.ready_in  = 1'b1;
    bus.signal_in = 16'sd300;
    bus.delays_in = pd(0, 0, 0, 0);
    bus.scales_in = pg(64, 0, 0, 0);
    exp = model(16'sd300, pd(0, 0, 0, 0), pg(64, 0, 0, 0));
    @(posedge clk_in);
    #1;
    bus.ready_in = 1'b0;
    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    bus.ready_in  = 1'b1;
    bus.signal_in = 16'sd999;
    @(posedge clk_in);
    #1;
    bus.ready_in = 1'b0;
    check("drain_exit_done", longint'(bus.done_out), 1);
    check("drain_exit_value", longint'($signed(bus.signal_out)), exp);
    check("drain_exit_dropped", longint'(bus.dropped_out), 1);

    // Neither dropped sample may have reached the history or the fill count.
    exp = model(16'sd40, pd(1, 2, 3, 0), pg(64, 64, 64, 0));
    run_one(16'sd40, pd(1, 2, 3, 0), pg(64, 64, 64, 0), out, lat);
    check("fill_after_drops", out, exp);
    check("fill_after_drops_direct", out, 800);

    // ---------------- reset mid-RUN ----------------
    run_one(16'sd1000, pd(0, 0, 0, 0), pg(64, 0, 0, 0), out, lat);
    check("pre_abort_value", out, 1000);
    @(negedge clk_in);
    bus.ready_in  = 1'b1;
    bus.signal_in = 16'sd2222;
    @(posedge clk_in);
    #1;
    bus.ready_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check("abort_signal_out", longint'($signed(bus.signal_out)), 0);
    check("abort_busy_out", longint'(bus.busy_out), 0);
    check("abort_done_out", longint'(bus.done_out), 0);
    hist.delete();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_in);
      #1;
      if (bus.done_out)
        ndone++;
    end
    check("abort_no_done", ndone, 0);
    exp = model(16'sd5, pd(1, 0, 0, 0), pg(64, 0, 0, 0));
    run_one(16'sd5, pd(1, 0, 0, 0), pg(64, 0, 0, 0), out, lat);
    check("abort_next_masked", out, 0);
    check("abort_next_model", out, exp);
    check("abort_next_latency", lat, 6);

    // ---------------- wrap-around ramp ----------------
    do_reset();
    for (int i = 0; i < 300; i++) begin
      exp = model(16'(i + 1), pd(255, 0, 0, 0), pg(64, 0, 0, 0));
      run_one(16'(i + 1), pd(255, 0, 0, 0), pg(64, 0, 0, 0), out, lat);
      check($sformatf("wrap_%0d", i), out, exp);
      if (i == 299)
        check("wrap_last_direct", out, 45);
    end

    // ---------------- randomized against the model ----------------
    do_reset();
    for (int i = 0; i < 80; i++) begin
      logic signed [15:0] s;
      logic [31:0]        d;
      logic [35:0]        g;
      s = 16'($urandom);
      if (i % 4 == 0)
        d = pd($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      else
        d = $urandom;
      g = {4'($urandom), $urandom};
      exp = model(s, d, g);
      run_one(s, d, g, out, lat);
      check($sformatf("rand_%0d", i), out, exp);
      if (lat != 6)
        check($sformatf("rand_%0d_latency", i), lat, 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
